// File: rtl/spi_ctrl_engine.sv
// SPI mode-0 (CPOL=0, CPHA=0) MSB-first controller: one valid/ready command per word, one-cycle
// response strobe. Define SPI_CTRL_BURST_EN to add cmd_last_i and multi-word frames (HOLD state).
module spi_ctrl_engine #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [DATA_W-1:0] cmd_data_i,
`ifdef SPI_CTRL_BURST_EN
   input  logic              cmd_last_i,
`endif
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              busy_o,
   output logic              spi_csn_o,
   output logic              spi_sclk_o,
   output logic              spi_sdi_o,
   input  logic              spi_sdo_i
);

   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CntW = $clog2(DATA_W + 1);
   localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DATA_W);

   typedef enum logic [2:0] {
      StIdle,
      StLead,
      StShift,
      StTrail,
`ifdef SPI_CTRL_BURST_EN
      StGap,
      StHold
`else
      StGap
`endif
   } state_e;

   state_e            state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              csn_q, csn_d;
   logic              sclk_q, sclk_d;
   logic              sdi_q, sdi_d;
   logic              ready_q, ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              busy_q, busy_d;
`ifdef SPI_CTRL_BURST_EN
   logic              last_q, last_d;
`endif

   logic tick;
   logic accept;

   assign tick   = (div_q == DivMax);
   // ready_q is only ever high in IDLE or HOLD, so accept needs no state qualifier
   assign accept = cmd_valid_i & ready_q;

   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      csn_d       = csn_q;
      sclk_d      = sclk_q;
      sdi_d       = sdi_q;
      ready_d     = ready_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
`ifdef SPI_CTRL_BURST_EN
      last_d      = last_q;
`endif

      if (state_q != StIdle
`ifdef SPI_CTRL_BURST_EN
          && state_q != StHold
`endif
         ) begin
         div_d = tick ? '0 : div_q + DivW'(1);
      end

      unique case (state_q)
         StIdle: ready_d = 1'b1;
         StLead: begin
            if (tick) begin
               sclk_d  = 1'b1;
               sh_d    = {sh_q[DATA_W-2:0], spi_sdo_i};
               cnt_d   = cnt_q + CntW'(1);
               state_d = StShift;
            end
         end
         StShift: begin
            if (tick) begin
               if (sclk_q) begin
                  sclk_d = 1'b0;
                  if (cnt_q != CntMax) sdi_d = sh_q[DATA_W-1];
               end else if (cnt_q == CntMax) begin
                  // Word ends after the low half-period following the last falling edge
`ifdef SPI_CTRL_BURST_EN
                  if (last_q) begin
                     state_d = StTrail;
                  end else begin
                     state_d     = StHold;
                     rsp_valid_d = 1'b1;
                     rsp_data_d  = sh_q;
                     ready_d     = 1'b1;
                  end
`else
                  state_d = StTrail;
`endif
               end else begin
                  sclk_d = 1'b1;
                  sh_d   = {sh_q[DATA_W-2:0], spi_sdo_i};
                  cnt_d  = cnt_q + CntW'(1);
               end
            end
         end
         StTrail: begin
            if (tick) begin
               csn_d       = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_data_d  = sh_q;
               state_d     = StGap;
            end
         end
         StGap: begin
            if (tick) begin
               ready_d = 1'b1;
               state_d = StIdle;
            end
         end
`ifdef SPI_CTRL_BURST_EN
         StHold: ready_d = 1'b1;
`endif
         default: state_d = StIdle;
      endcase

      if (accept) begin
         ready_d = 1'b0;
         sh_d    = cmd_data_i;
         sdi_d   = cmd_data_i[DATA_W-1];
         csn_d   = 1'b0;
         cnt_d   = '0;
         div_d   = '0;
         state_d = StLead;
`ifdef SPI_CTRL_BURST_EN
         last_d  = cmd_last_i;
`endif
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         div_q       <= '0;
         cnt_q       <= '0;
         sh_q        <= '0;
         csn_q       <= 1'b1;
         sclk_q      <= 1'b0;
         sdi_q       <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         csn_q       <= csn_d;
         sclk_q      <= sclk_d;
         sdi_q       <= sdi_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
      end
   end

`ifdef SPI_CTRL_BURST_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= 1'b1;
      else        last_q <= last_d;
   end
`endif

   assign cmd_ready_o = ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign busy_o      = busy_q;
   assign spi_csn_o   = csn_q;
   assign spi_sclk_o  = sclk_q;
   assign spi_sdi_o   = sdi_q;

endmodule

// File: tb/tb_spi_ctrl_engine.sv
// Bench for spi_ctrl_engine: DUT a (8-bit, div 2) with a mode-0 responder model, DUT b (16-bit,
// div 1) in loopback. Burst checks are built only when SPI_CTRL_BURST_EN is defined.
module tb_spi_ctrl_engine;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        cmd_valid_a, cmd_ready_a, rsp_valid_a, busy_a;
   logic [7:0]  cmd_data_a, rsp_data_a, rx_next_a;
   logic        spi_csn_a, spi_sclk_a, spi_sdi_a, spi_sdo_a;
`ifdef SPI_CTRL_BURST_EN
   logic        cmd_last_a;
`endif
   logic        cmd_valid_b, cmd_ready_b, rsp_valid_b, busy_b;
   logic [15:0] cmd_data_b, rsp_data_b;
   logic        spi_csn_b, spi_sclk_b, spi_sdi_b;

   spi_ctrl_engine #(.DATA_W(8), .CLK_DIV(2)) u_dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid_i (cmd_valid_a),
      .cmd_ready_o (cmd_ready_a),
      .cmd_data_i  (cmd_data_a),
`ifdef SPI_CTRL_BURST_EN
      .cmd_last_i  (cmd_last_a),
`endif
      .rsp_valid_o (rsp_valid_a),
      .rsp_data_o  (rsp_data_a),
      .busy_o      (busy_a),
      .spi_csn_o   (spi_csn_a),
      .spi_sclk_o  (spi_sclk_a),
      .spi_sdi_o   (spi_sdi_a),
      .spi_sdo_i   (spi_sdo_a)
   );

   spi_ctrl_engine #(.DATA_W(16), .CLK_DIV(1)) u_dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid_i (cmd_valid_b),
      .cmd_ready_o (cmd_ready_b),
      .cmd_data_i  (cmd_data_b),
`ifdef SPI_CTRL_BURST_EN
      .cmd_last_i  (1'b1),
`endif
      .rsp_valid_o (rsp_valid_b),
      .rsp_data_o  (rsp_data_b),
      .busy_o      (busy_b),
      .spi_csn_o   (spi_csn_b),
      .spi_sclk_o  (spi_sclk_b),
      .spi_sdi_o   (spi_sdi_b),
      .spi_sdo_i   (spi_sdi_b)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // Scoreboards: {tx, rx} for a, tx (== rx in loopback) for b
   logic [15:0] sb_a[$];
   logic [15:0] sb_b[$];
   logic [15:0] e_a, e_b;
   logic [7:0]  resp_sh_a = '0;
   logic [7:0]  txcap_a = '0;
   logic [15:0] txcap_b = '0;
   assign spi_sdo_a = resp_sh_a[7];

   int cyc = 0;
   int acc_cyc_a, rsp_cyc_a, first_rise_a, rsp_cnt_a = 0;
   int rise_fr_a = 0, last_rises_a = 0, low_cnt_a = 0, high_cnt_a = 0;
   int last_low_a = 0, last_high_a = 0;
   int rise_b = 0, last_rise_b = 0, min_per_b = 0, max_per_b = 0, rsp_cnt_b = 0;
   logic prev_csn_a = 1'b1, prev_sclk_a = 1'b0, prev_rsp_a = 1'b0, prev_sclk_b = 1'b0;

   // Monitor / responder, sampled on the falling clk edge
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!spi_csn_a && prev_csn_a) begin
            last_high_a = high_cnt_a;
            rise_fr_a   = 0;
            low_cnt_a   = 0;
         end
         if (spi_csn_a && !prev_csn_a) begin
            last_low_a   = low_cnt_a;
            last_rises_a = rise_fr_a;
            high_cnt_a   = 0;
         end
         if (spi_csn_a) high_cnt_a++;
         else           low_cnt_a++;

         if (!rst_n) begin
            sb_a.delete();
            sb_b.delete();
            resp_sh_a = '0;
         end else begin
            if (cmd_valid_a && cmd_ready_a) begin
               sb_a.push_back({cmd_data_a, rx_next_a});
               resp_sh_a = rx_next_a;
               acc_cyc_a = cyc;
            end
            if (spi_sclk_a && !prev_sclk_a) begin
               rise_fr_a++;
               txcap_a   = {txcap_a[6:0], spi_sdi_a};
               resp_sh_a = resp_sh_a << 1;
               if (rise_fr_a == 1) first_rise_a = cyc;
            end
            if (rsp_valid_a) begin
               rsp_cnt_a++;
               rsp_cyc_a = cyc;
               check_val("rsp_pulse_a", 32'(prev_rsp_a), 32'd0);
               if (sb_a.size() == 0) begin
                  check_val("rsp_unexpected_a", 32'(rsp_valid_a), 32'd0);
               end else begin
                  e_a = sb_a.pop_front();
                  check_val("rsp_data_a", 32'(rsp_data_a), 32'(e_a[7:0]));
                  check_val("tx_bits_a", 32'(txcap_a), 32'(e_a[15:8]));
               end
            end

            if (cmd_valid_b && cmd_ready_b) begin
               sb_b.push_back(cmd_data_b);
               rise_b    = 0;
               min_per_b = 1000;
               max_per_b = 0;
            end
            if (spi_sclk_b && !prev_sclk_b) begin
               rise_b++;
               txcap_b = {txcap_b[14:0], spi_sdi_b};
               if (rise_b > 1) begin
                  if (cyc - last_rise_b < min_per_b) min_per_b = cyc - last_rise_b;
                  if (cyc - last_rise_b > max_per_b) max_per_b = cyc - last_rise_b;
               end
               last_rise_b = cyc;
            end
            if (rsp_valid_b) begin
               rsp_cnt_b++;
               if (sb_b.size() == 0) begin
                  check_val("rsp_unexpected_b", 32'(rsp_valid_b), 32'd0);
               end else begin
                  e_b = sb_b.pop_front();
                  check_val("rsp_data_b", 32'(rsp_data_b), 32'(e_b));
                  check_val("tx_bits_b", 32'(txcap_b), 32'(e_b));
               end
            end
         end
         prev_csn_a  = spi_csn_a;
         prev_sclk_a = spi_sclk_a;
         prev_rsp_a  = rsp_valid_a;
         prev_sclk_b = spi_sclk_b;
      end
   end

`ifdef SPI_CTRL_BURST_EN
   task automatic send_a(input logic [7:0] tx, input logic [7:0] rx, input logic last = 1'b1);
`else
   task automatic send_a(input logic [7:0] tx, input logic [7:0] rx);
`endif
      int n;
      @(posedge clk);
      #1;
      cmd_valid_a = 1'b1;
      cmd_data_a  = tx;
      rx_next_a   = rx;
`ifdef SPI_CTRL_BURST_EN
      cmd_last_a  = last;
`endif
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cmd_ready_a && n < 500);
      if (!cmd_ready_a) check_val("accept_timeout_a", 32'(cmd_ready_a), 32'd1);
      @(posedge clk);
      #1;
      cmd_valid_a = 1'b0;
   endtask

   task automatic wait_done_a();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while ((sb_a.size() != 0 || !cmd_ready_a) && n < 500);
      if (n >= 500) check_val("done_timeout_a", 32'(sb_a.size()), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int cnt0, n;

   initial begin
      rst_n       = 1'b0;
      cmd_valid_a = 1'b0;
      cmd_data_a  = '0;
      rx_next_a   = '0;
`ifdef SPI_CTRL_BURST_EN
      cmd_last_a  = 1'b1;
`endif
      cmd_valid_b = 1'b0;
      cmd_data_b  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_csn", 32'(spi_csn_a), 32'd1);
      check_val("rst_sclk", 32'(spi_sclk_a), 32'd0);
      check_val("rst_sdi", 32'(spi_sdi_a), 32'd0);
      check_val("rst_ready", 32'(cmd_ready_a), 32'd0);
      check_val("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
      check_val("rst_rsp_data", 32'(rsp_data_a), 32'd0);
      check_val("rst_busy", 32'(busy_a), 32'd0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check_val("ready_before_edge", 32'(cmd_ready_a), 32'd0);
      @(posedge clk);
      #1;
      check_val("ready_after_edge", 32'(cmd_ready_a), 32'd1);

      // Single word: A5 out, 3C back
      cnt0 = rsp_cnt_a;
      send_a(8'hA5, 8'h3C);
      wait_done_a();
      check_val("first_rise_lat", 32'(first_rise_a - acc_cyc_a), 32'd3);
      check_val("csn_low_len", 32'(last_low_a), 32'd36);
      check_val("rsp_lat", 32'(rsp_cyc_a - acc_cyc_a), 32'd37);
      check_val("rsp_count_1", 32'(rsp_cnt_a - cnt0), 32'd1);

      // Back-to-back
      send_a(8'h01, 8'hFF);
      send_a(8'h80, 8'h00);
      check_val("b2b_accept_gap", 32'(acc_cyc_a - rsp_cyc_a), 32'd2);
      wait_done_a();
      check_val("b2b_csn_high", 32'(last_high_a), 32'd3);
      check_val("b2b_csn_low", 32'(last_low_a), 32'd36);

      // DATA_W=16, CLK_DIV=1 loopback
      @(posedge clk);
      #1;
      cmd_valid_b = 1'b1;
      cmd_data_b  = 16'hBEEF;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cmd_ready_b && n < 500);
      @(posedge clk);
      #1;
      cmd_valid_b = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while ((sb_b.size() != 0 || !cmd_ready_b) && n < 500);
      check_val("b_done", 32'(cmd_ready_b), 32'd1);
      check_val("b_rises", 32'(rise_b), 32'd16);
      check_val("b_min_period", 32'(min_per_b), 32'd2);
      check_val("b_max_period", 32'(max_per_b), 32'd2);
      check_val("b_rsp_count", 32'(rsp_cnt_b), 32'd1);

      // Command presented while busy is held off until IDLE
      send_a(8'h96, 8'h69);
      for (int i = 0; i < 10; i++) begin
         cmd_valid_a = (i % 2 == 0);
         cmd_data_a  = 8'h3E;
         @(negedge clk);
         check_val("ready_while_busy", 32'(cmd_ready_a), 32'd0);
         @(posedge clk);
         #1;
      end
      send_a(8'h3E, 8'hE3);
      check_val("pending_accept_gap", 32'(acc_cyc_a - rsp_cyc_a), 32'd2);
      wait_done_a();

`ifdef SPI_CTRL_BURST_EN
      cnt0 = rsp_cnt_a;
      send_a(8'h11, 8'hA1, 1'b0);
      wait_done_a();
      repeat (20) @(posedge clk);
      #1;
      check_val("hold_csn", 32'(spi_csn_a), 32'd0);
      check_val("hold_sclk", 32'(spi_sclk_a), 32'd0);
      check_val("hold_ready", 32'(cmd_ready_a), 32'd1);
      send_a(8'h22, 8'hB2, 1'b1);
      wait_done_a();
      check_val("burst_rises", 32'(last_rises_a), 32'd16);
      check_val("burst_rsp_count", 32'(rsp_cnt_a - cnt0), 32'd2);
`endif

      // Reset after the third sclk rise
      send_a(8'hC6, 8'h0F);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (rise_fr_a < 3 && n < 500);
      check_val("abort_reached_rise3", 32'(rise_fr_a), 32'd3);
      cnt0 = rsp_cnt_a;
      rst_n = 1'b0;
      #1;
      check_val("abort_csn", 32'(spi_csn_a), 32'd1);
      check_val("abort_sclk", 32'(spi_sclk_a), 32'd0);
      check_val("abort_busy", 32'(busy_a), 32'd0);
      check_val("abort_rsp_valid", 32'(rsp_valid_a), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      send_a(8'h5A, 8'hC3);
      wait_done_a();
      check_val("post_reset_rsp_count", 32'(rsp_cnt_a - cnt0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
